dac_update_sched: RTL
=====================

Name: dac_update_sched

Overview:
- Sequences updates of the 16-bit DAC7731 output word that feeds the serial DAC interface.
- Shares the DAC between NREQ requesters using round-robin arbitration.
- Slews the output toward each granted target code in steps, aligned to DAC frame boundaries.
- Holds a settle interval after each update, then signals completion to the owning requester.

Parameters:
NREQ, 4, number of requesters (2..8)
SETTLE_FRAMES, 2, frame_tick pulses to wait after target is reached before done (1..15)
RESET_CODE, 16'h8000, dac_data value after reset (midscale, offset binary)

Ports:
clk_ref  input  1  20 MHz system clock; all logic on posedge
sys_rstn  input  1  reset, asynchronous, active-low
req  input  NREQ  per-requester update request, level
req_code  input  16*NREQ  target codes; requester i uses bits [16*i+15:16*i]
ramp_en  input  1  1 = slew by ramp_step per frame; 0 = jump to target
ramp_step  input  16  slew increment, unsigned; 0 behaves as jump
frame_tick  input  1  one-cycle pulse each time the serial interface loads a new word
dac_data  output  16  word presented to the serial interface; changes only on frame_tick cycles
gnt  output  NREQ  one-hot owner indication, level, high from grant until done
done  output  NREQ  one-cycle completion pulse to the owner
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; dac_data=RESET_CODE; gnt=0; done=0; busy=0; rr_ptr=0; settle_cnt=0.
- States: IDLE, RAMP, SETTLE.
- IDLE, no req bits set: remain in IDLE.
- IDLE, any req bit set: select the first set bit searching from rr_ptr upward, wrapping at NREQ.
  - Next cycle: gnt[i]=1, target<=req_code[i], owner<=i.
  - If target==dac_data, go to SETTLE; otherwise go to RAMP.
- Grant-cycle frame_tick: a frame_tick in the grant-decision cycle is ignored. Ramping starts on the first frame_tick after gnt rises.
- RAMP, on each frame_tick: compute diff=|target-dac_data| with 17-bit arithmetic.
  - If ramp_en=0, or ramp_step=0, or diff<=ramp_step: dac_data<=target.
  - Otherwise: dac_data<=dac_data+ramp_step when target>dac_data, else dac_data-ramp_step.
  - No wrap-around or overshoot is possible.
  - When the updated dac_data equals target: settle_cnt<=0 and go to SETTLE.
- RAMP, no frame_tick: dac_data holds.
- SETTLE: settle_cnt increments on each frame_tick.
  - On the frame_tick where settle_cnt reaches SETTLE_FRAMES-1: done[owner]=1 for the following cycle, gnt cleared in that same cycle, rr_ptr<=(owner+1) mod NREQ, state<=IDLE.
- Earliest next grant: in the cycle after done.
- req/req_code sampling: sampled only in the IDLE grant decision. Deasserting req or changing req_code while owned does not abort or retarget; the transfer completes and done still pulses.
- Input stability: ramp_en and ramp_step are sampled at each frame_tick and may change mid-ramp.
- dac_data update timing: changes only in the cycle after a frame_tick, so the serial interface never captures a mid-update word.
- Reset mid-operation: all outputs return to reset values immediately; dac_data=RESET_CODE; no done pulse is generated.
- Latency for a jump (ramp_en=0): gnt at cycle 1 after req; dac_data updates after the 1st frame_tick; done after frame_tick number 1+SETTLE_FRAMES.

Test Plan:
- Reset: hold sys_rstn low with req=4'b1111 -> dac_data=16'h8000, gnt=0, done=0, busy=0. Release -> gnt=4'b0001 one cycle after the first clock edge.
- Single ramp up: req[0], code 16'h8100, ramp_en=1, step 16'h0040 -> dac_data 8040, 80C0… actually 8040, 8080, 80C0, 8100 on ticks 1-4; done[0] pulse after tick 6 (SETTLE_FRAMES=2); busy low after done.
- Clamp/no wrap: from 16'h0050, target 16'h0010, step 16'h0030 -> 0020 then 0010. From 16'hFFF0, target 16'hFFFF, step 16'h0040 -> FFFF in one tick.
- Round-robin: req=4'b1111 held -> grant order 0,1,2,3. Then req=4'b1001 after owner 3 -> next grant 0, then 3.
- Jump and equal target: ramp_en=0, req[2] code 16'h1234 -> dac_data=1234 on tick 1. Then req[2] code 16'h1234 again -> goes directly to SETTLE; done[2] after 2 ticks; dac_data unchanged.
- Reset mid-ramp: assert sys_rstn low during RAMP at dac_data=80C0 -> dac_data=8000, gnt=0, no done. After release, a pending req is re-granted starting from rr_ptr=0.

Source files
------------

// File: rtl/dac_update_sched_if.sv
// Request/grant and DAC word bundle between requesters, the update scheduler and the serial DAC link.
// Purely combinational wiring; no latency or flow control of its own.
interface dac_update_sched_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]    req;
   logic [16*NREQ-1:0] req_code;
   logic               ramp_en;
   logic [15:0]        ramp_step;
   logic               frame_tick;
   logic [15:0]        dac_data;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic               busy;

   modport master (
      output req, req_code, ramp_en, ramp_step, frame_tick,
      input  dac_data, gnt, done, busy
   );

   modport slave (
      input  req, req_code, ramp_en, ramp_step, frame_tick,
      output dac_data, gnt, done, busy
   );
endinterface

// File: rtl/dac_update_sched.sv
// Round-robin scheduler that slews the DAC word toward a granted target on frame ticks, then settles.
// gnt one cycle after req; dac_data moves only after frame_tick; requesters wait on gnt/done.
module dac_update_sched #(
   parameter int          NREQ          = 4,
   parameter int          SETTLE_FRAMES = 2,
   parameter logic [15:0] RESET_CODE    = 16'h8000
) (
   input logic               clk_ref,
   input logic               sys_rstn,
   dac_update_sched_if.slave sched_if
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = 4;
   localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
   localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RAMP,
      SETTLE
   } state_t;

   state_t            state_q;
   logic [15:0]       dac_q;
   logic [15:0]       dac_d;
   logic [15:0]       target_q;
   logic [NREQ-1:0]   gnt_q;
   logic [NREQ-1:0]   done_q;
   logic              busy_q;
   logic [PW-1:0]     rr_ptr_q;
   logic [PW-1:0]     owner_q;
   logic [CW-1:0]     settle_cnt_q;

   logic              pick_vld;
   logic [PW-1:0]     pick_idx;
   logic [PW-1:0]     try_idx;
   logic [15:0]       pick_code;

   // First requester at or after rr_ptr, wrapping at NREQ.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      try_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         try_idx = PW'((int'(rr_ptr_q) + k) % NREQ);
         if (!pick_vld && sched_if.req[try_idx]) begin
            pick_vld = 1'b1;
            pick_idx = try_idx;
         end
      end
   end

   always_comb begin
      pick_code = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (PW'(k) == pick_idx) begin
            pick_code = sched_if.req_code[16*k +: 16];
         end
      end
   end

   logic        ramp_up;
   logic [16:0] ramp_diff;

   // Final step snaps to target, so the slew can never overshoot or wrap.
   always_comb begin
      ramp_up   = target_q > dac_q;
      ramp_diff = ramp_up ? ({1'b0, target_q} - {1'b0, dac_q})
                          : ({1'b0, dac_q} - {1'b0, target_q});
      if (!sched_if.ramp_en || (sched_if.ramp_step == 16'h0000) ||
          (ramp_diff <= {1'b0, sched_if.ramp_step})) begin
         dac_d = target_q;
      end else if (ramp_up) begin
         dac_d = dac_q + sched_if.ramp_step;
      end else begin
         dac_d = dac_q - sched_if.ramp_step;
      end
   end

   always_ff @(posedge clk_ref or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_q      <= IDLE;
         dac_q        <= RESET_CODE;
         target_q     <= RESET_CODE;
         gnt_q        <= '0;
         done_q       <= '0;
         busy_q       <= 1'b0;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         settle_cnt_q <= '0;
      end else begin
         done_q <= '0;
         case (state_q)
            IDLE: begin
               // A frame_tick in the grant cycle is deliberately not acted on.
               if (pick_vld) begin
                  gnt_q        <= ONE_HOT0 << pick_idx;
                  owner_q      <= pick_idx;
                  target_q     <= pick_code;
                  settle_cnt_q <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= (pick_code == dac_q) ? SETTLE : RAMP;
               end
            end
            RAMP: begin
               if (sched_if.frame_tick) begin
                  dac_q <= dac_d;
                  if (dac_d == target_q) begin
                     settle_cnt_q <= '0;
                     state_q      <= SETTLE;
                  end
               end
            end
            SETTLE: begin
               if (sched_if.frame_tick) begin
                  if (settle_cnt_q == SETTLE_LAST) begin
                     done_q   <= ONE_HOT0 << owner_q;
                     gnt_q    <= '0;
                     busy_q   <= 1'b0;
                     rr_ptr_q <= (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                     state_q  <= IDLE;
                  end else begin
                     settle_cnt_q <= settle_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign sched_if.dac_data = dac_q;
   assign sched_if.gnt      = gnt_q;
   assign sched_if.done     = done_q;
   assign sched_if.busy     = busy_q;
endmodule
